// File: rtl/ctrl_pkg.sv
// Shared encodings for the interrupt controller: FSM states, acknowledge
// type codes and the default line count.
package ctrl_pkg;

    localparam int NUM_IRQ_DEF = 4;

    // Maskable-path FSM states (plain constants for legacy tools)
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] INT_REQ = 2'd1;
    localparam logic [1:0] SERVICE = 2'd2;

    // INA acknowledge type from the CPU controller
    localparam logic INA_INT = 1'b1;
    localparam logic INA_NMI = 1'b0;

endpackage

// File: rtl/irq_priority_enc.sv
// Combinational priority encoder: lowest set index wins.
module irq_priority_enc #(
    parameter int NUM_IRQ = 4,
    parameter int VEC_W   = 2
) (
    input  logic [NUM_IRQ-1:0] req_i,
    output logic [VEC_W-1:0]   idx_o,
    output logic               valid_o
);

    // Scan from the top down so the lowest requesting index is left last
    always_comb begin
        idx_o   = '0;
        valid_o = |req_i;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (req_i[i]) idx_o = VEC_W'(i);
        end
    end

endmodule

// File: rtl/interrupt_controller.sv
// Edge-capturing interrupt controller: NUM_IRQ maskable lines plus one NMI,
// presented to the CPU as a prioritised INT/NMI pair with ack and EOI.
module interrupt_controller
    import ctrl_pkg::*;
#(
    parameter int NUM_IRQ = NUM_IRQ_DEF,
    parameter int VEC_W   = 2
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic [NUM_IRQ-1:0] Irq,
    input  logic               NmiSrc,
    input  logic               MaskWe,
    input  logic [NUM_IRQ-1:0] MaskIn,
    input  logic               INTD,
    input  logic               isInterrupted,
    input  logic               INA,
    input  logic               Eoi,
    output logic               INT,
    output logic               NMI,
    output logic [VEC_W-1:0]   IrqVec,
    output logic               InService,
    output logic               NmiActive,
    output logic [NUM_IRQ-1:0] Pending,
    output logic [NUM_IRQ-1:0] Mask
);

    logic [NUM_IRQ-1:0] irq_q;
    logic [NUM_IRQ-1:0] pend_q, pend_d;
    logic [NUM_IRQ-1:0] mask_q, mask_d;
    logic               nmi_q;
    logic               nmi_pend_q, nmi_pend_d;
    logic               nmi_act_q, nmi_act_d;
    logic [1:0]         state_q, state_d;
    logic               int_q, int_d;
    logic               insvc_q, insvc_d;
    logic [VEC_W-1:0]   vec_q, vec_d;

    logic [NUM_IRQ-1:0] irq_edge;
    logic [NUM_IRQ-1:0] pend_clr;
    logic [NUM_IRQ-1:0] eligible;
    logic [VEC_W-1:0]   enc_idx;
    logic               enc_vld;
    logic               nmi_edge;
    logic               ack_int;
    logic               ack_nmi;

    assign irq_edge = Irq & ~irq_q;
    assign nmi_edge = NmiSrc & ~nmi_q;
    assign eligible = pend_q & ~mask_q;
    assign ack_int  = isInterrupted && (INA == INA_INT);
    assign ack_nmi  = isInterrupted && (INA == INA_NMI) && nmi_pend_q;

    irq_priority_enc #(
        .NUM_IRQ (NUM_IRQ),
        .VEC_W   (VEC_W)
    ) u_enc (
        .req_i   (eligible),
        .idx_o   (enc_idx),
        .valid_o (enc_vld)
    );

    // Maskable request FSM plus pending/mask bookkeeping
    always_comb begin
        state_d  = state_q;
        int_d    = int_q;
        insvc_d  = insvc_q;
        vec_d    = vec_q;
        pend_clr = '0;
        mask_d   = MaskWe ? MaskIn : mask_q;

        case (state_q)
            IDLE: begin
                if (enc_vld && !INTD) begin
                    vec_d   = enc_idx;
                    int_d   = 1'b1;
                    state_d = INT_REQ;
                end
            end
            INT_REQ: begin
                // INTD is only a gate for raising; a raised INT stays up
                if (ack_int) begin
                    pend_clr[vec_q] = 1'b1;
                    int_d           = 1'b0;
                    insvc_d         = 1'b1;
                    state_d         = SERVICE;
                end else if (mask_q[vec_q]) begin
                    int_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            SERVICE: begin
                // An EOI while an NMI is nested belongs to the NMI
                if (Eoi && !nmi_act_q) begin
                    insvc_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                int_d   = 1'b0;
                insvc_d = 1'b0;
                state_d = IDLE;
            end
        endcase

        // A new edge beats a same-cycle clear
        pend_d = (pend_q & ~pend_clr) | irq_edge;
    end

    // NMI path, independent of the maskable FSM
    always_comb begin
        nmi_pend_d = (nmi_pend_q & ~ack_nmi) | nmi_edge;
        nmi_act_d  = nmi_act_q;
        if (ack_nmi)
            nmi_act_d = 1'b1;
        else if (Eoi && nmi_act_q)
            nmi_act_d = 1'b0;
    end

    // State registers; mask comes out of reset fully masked
    always_ff @(posedge Clk) begin
        if (Reset) begin
            irq_q      <= '0;
            pend_q     <= '0;
            mask_q     <= '1;
            nmi_q      <= 1'b0;
            nmi_pend_q <= 1'b0;
            nmi_act_q  <= 1'b0;
            state_q    <= IDLE;
            int_q      <= 1'b0;
            insvc_q    <= 1'b0;
            vec_q      <= '0;
        end else begin
            irq_q      <= Irq;
            pend_q     <= pend_d;
            mask_q     <= mask_d;
            nmi_q      <= NmiSrc;
            nmi_pend_q <= nmi_pend_d;
            nmi_act_q  <= nmi_act_d;
            state_q    <= state_d;
            int_q      <= int_d;
            insvc_q    <= insvc_d;
            vec_q      <= vec_d;
        end
    end

    assign INT       = int_q;
    assign NMI       = nmi_pend_q;
    assign IrqVec    = vec_q;
    assign InService = insvc_q;
    assign NmiActive = nmi_act_q;
    assign Pending   = pend_q;
    assign Mask      = mask_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller with hand-computed expectations.
module tb_interrupt_controller;

    logic       Clk = 1'b0;
    logic       Reset;
    logic [3:0] Irq;
    logic       NmiSrc;
    logic       MaskWe;
    logic [3:0] MaskIn;
    logic       INTD;
    logic       isInterrupted;
    logic       INA;
    logic       Eoi;
    logic       INT;
    logic       NMI;
    logic [1:0] IrqVec;
    logic       InService;
    logic       NmiActive;
    logic [3:0] Pending;
    logic [3:0] Mask;

    int tests = 0;
    int fails = 0;

    interrupt_controller #(.NUM_IRQ(4), .VEC_W(2)) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .Irq           (Irq),
        .NmiSrc        (NmiSrc),
        .MaskWe        (MaskWe),
        .MaskIn        (MaskIn),
        .INTD          (INTD),
        .isInterrupted (isInterrupted),
        .INA           (INA),
        .Eoi           (Eoi),
        .INT           (INT),
        .NMI           (NMI),
        .IrqVec        (IrqVec),
        .InService     (InService),
        .NmiActive     (NmiActive),
        .Pending       (Pending),
        .Mask          (Mask)
    );

    always #5 Clk = ~Clk;

    // Advance one rising edge; inputs changed and outputs sampled 1ns later
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One-cycle pulse helpers
    task automatic ack(input logic ina);
        isInterrupted = 1'b1; INA = ina;
        step();
        isInterrupted = 1'b0; INA = 1'b0;
    endtask

    task automatic eoi();
        Eoi = 1'b1;
        step();
        Eoi = 1'b0;
    endtask

    initial begin
        Reset = 1'b1; Irq = '0; NmiSrc = 1'b0; MaskWe = 1'b0; MaskIn = '0;
        INTD = 1'b0; isInterrupted = 1'b0; INA = 1'b0; Eoi = 1'b0;
        step(); step();

        // Reset state
        chk("rst_int",  INT, 0);
        chk("rst_nmi",  NMI, 0);
        chk("rst_mask", Mask, 4'hF);
        chk("rst_pend", Pending, 0);
        chk("rst_svc",  InService, 0);
        chk("rst_vec",  IrqVec, 0);
        Reset = 1'b0;

        // 1: single line, full handshake
        MaskWe = 1'b1; MaskIn = 4'b0000; step(); MaskWe = 1'b0;
        chk("t1_mask", Mask, 0);
        Irq = 4'b0100; step();
        chk("t1_pend", Pending, 4'b0100);
        chk("t1_int_lat", INT, 0);
        step();
        chk("t1_int", INT, 1);
        chk("t1_vec", IrqVec, 2);
        ack(1'b0);                         // INA mismatch, no NMI pending
        chk("t1_bad_ack_int", INT, 1);
        chk("t1_bad_ack_svc", InService, 0);
        ack(1'b1);
        chk("t1_ack_int",  INT, 0);
        chk("t1_ack_svc",  InService, 1);
        chk("t1_ack_pend", Pending, 0);
        eoi();
        chk("t1_eoi_svc", InService, 0);

        // 2: simultaneous lines 3 and 1, lowest first
        Irq = 4'b1110; step();
        chk("t2_pend", Pending, 4'b1010);
        step();
        chk("t2_int1", INT, 1);
        chk("t2_vec1", IrqVec, 1);
        ack(1'b1);
        chk("t2_pend_after", Pending, 4'b1000);
        eoi();
        chk("t2_idle_int", INT, 0);
        step();
        chk("t2_int3", INT, 1);
        chk("t2_vec3", IrqVec, 3);
        ack(1'b1); eoi();
        Irq = 4'b0000; step();

        // 3: masked line held pending, released by mask write
        MaskWe = 1'b1; MaskIn = 4'b1111; step(); MaskWe = 1'b0;
        Irq = 4'b0001; step();
        chk("t3_pend", Pending, 4'b0001);
        step(); step();
        chk("t3_masked_int", INT, 0);
        MaskWe = 1'b1; MaskIn = 4'b0000; step(); MaskWe = 1'b0;
        chk("t3_int_wait", INT, 0);
        step();
        chk("t3_int", INT, 1);
        chk("t3_vec", IrqVec, 0);
        ack(1'b1); eoi();
        Irq = 4'b0000; step();

        // 4: INTD gates raising
        INTD = 1'b1;
        Irq = 4'b0001; step(); step(); step();
        chk("t4_intd_int", INT, 0);
        chk("t4_intd_pend", Pending, 4'b0001);
        INTD = 1'b0; step();
        chk("t4_int", INT, 1);
        INTD = 1'b1; step();               // INTD after raise does not withdraw
        chk("t4_int_held", INT, 1);
        INTD = 1'b0;
        ack(1'b1); eoi();

        // 5: NMI nested inside SERVICE of vector 2
        Irq = 4'b0100; step(); step();
        chk("t5_vec", IrqVec, 2);
        ack(1'b1);
        chk("t5_svc", InService, 1);
        NmiSrc = 1'b1; step();
        chk("t5_nmi", NMI, 1);
        ack(1'b0);
        chk("t5_nmi_ack", NMI, 0);
        chk("t5_nmiact", NmiActive, 1);
        eoi();
        chk("t5_nmi_eoi", NmiActive, 0);
        chk("t5_svc_kept", InService, 1);
        eoi();
        chk("t5_svc_eoi", InService, 0);
        chk("t5_vec_held", IrqVec, 2);

        // 6: edge coinciding with ack, then reset in INT_REQ
        Irq = 4'b0000; NmiSrc = 1'b0; step();
        Irq = 4'b0010; step(); step();
        chk("t6_vec", IrqVec, 1);
        Irq = 4'b0000; step();
        Irq = 4'b0010;
        ack(1'b1);
        chk("t6_pend_kept", Pending, 4'b0010);
        chk("t6_svc", InService, 1);
        eoi();
        step();
        chk("t6_reint", INT, 1);
        chk("t6_revec", IrqVec, 1);
        // Mask withdraw of a raised request keeps it pending
        MaskWe = 1'b1; MaskIn = 4'b0010; step(); MaskWe = 1'b0;
        step();
        chk("t6_withdraw_int", INT, 0);
        chk("t6_withdraw_pend", Pending, 4'b0010);
        MaskWe = 1'b1; MaskIn = 4'b0000; step(); MaskWe = 1'b0;
        step();
        chk("t6_reraise", INT, 1);
        Reset = 1'b1; step();
        chk("t6_rst_int",  INT, 0);
        chk("t6_rst_mask", Mask, 4'hF);
        chk("t6_rst_pend", Pending, 0);
        chk("t6_rst_svc",  InService, 0);
        Reset = 1'b0; Irq = 4'b0000; step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Hard bound on run time
    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
- Collects NUM_IRQ maskable interrupt lines and one NMI source, latches edges as pending requests and applies a software-writable mask.
- Presents a single prioritised INT/NMI request pair to the multicycle CPU controller.
- Completes the handshake using the controller's isInterrupted/INA acknowledge and a CPU end-of-interrupt (Eoi) strobe.
- Sits between peripheral interrupt sources and the controller's INT, NMI and INTD inputs.

Parameters:
- NUM_IRQ, 4: number of maskable interrupt lines (2..16).
- VEC_W, 2: width of the vector output; must equal clog2(NUM_IRQ).

Ports:
- Clk  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  synchronous reset, active-high.
- Irq  input  NUM_IRQ  level interrupt sources; a rising edge requests service.
- NmiSrc  input  1  non-maskable source; a rising edge requests service.
- MaskWe  input  1  mask write strobe.
- MaskIn  input  NUM_IRQ  new mask value; bit set = line masked.
- INTD  input  1  global maskable-interrupt disable from the CPU.
- isInterrupted  input  1  acknowledge pulse from the CPU controller.
- INA  input  1  acknowledge type: 1 = INT, 0 = NMI.
- Eoi  input  1  end-of-interrupt strobe from the CPU.
- INT  output  1  maskable interrupt request to the CPU.
- NMI  output  1  non-maskable request to the CPU.
- IrqVec  output  VEC_W  index of the requested or in-service line.
- InService  output  1  a maskable interrupt is being serviced.
- NmiActive  output  1  an NMI is being serviced.
- Pending  output  NUM_IRQ  pending register, for status reads.
- Mask  output  NUM_IRQ  current mask register.

Behaviour:
- Reset values:
  - All outputs and internal registers are 0, except Mask, which resets to all-ones (everything masked).
  - irq_q and nmi_q (the previous-sample registers) reset to 0, so a source already high at reset release produces an edge on the first cycle.
- Edge capture:
  - irq_q registers Irq each cycle.
  - Pending[i] is set when Irq[i] & ~irq_q[i].
  - NMI edge detection works the same way through nmi_q and sets nmi_pend.
  - If a set and a clear hit the same bit in the same cycle, the set wins.
- Mask:
  - Mask <= MaskIn on MaskWe.
  - Masking a line does not clear its Pending bit; the bit is simply held back.
- Eligibility: a line is eligible when Pending & ~Mask is nonzero. Lowest index has highest priority (priority encoder).
- Maskable FSM states: IDLE, INT_REQ, SERVICE.
  - IDLE: if any line is eligible and INTD == 0:
    - IrqVec <= encoded index and INT <= 1; go to INT_REQ.
  - INT_REQ:
    - If isInterrupted & INA == 1: clear Pending[IrqVec], INT <= 0, InService <= 1; go to SERVICE.
    - Else, if Mask[IrqVec] becomes 1: withdraw with INT <= 0 and return to IDLE. Pending is kept.
    - INTD rising while in INT_REQ does not withdraw an INT that is already raised.
  - SERVICE:
    - Eoi with NmiActive == 0 sets InService <= 0; go to IDLE.
    - New pending lines accumulate here but are not presented.
    - IrqVec is held.
  - Eoi in IDLE or INT_REQ is ignored.
- NMI path (independent of the FSM):
  - NMI output equals the nmi_pend register.
  - isInterrupted & INA == 0 with nmi_pend set: nmi_pend <= 0, NmiActive <= 1.
  - NMI may interrupt SERVICE.
  - Eoi while NmiActive: only NmiActive clears; InService is unaffected.
  - An NMI edge arriving while NmiActive sets nmi_pend again and is re-presented.
- Latency:
  - Irq edge at cycle t → Pending set at t+1 → INT high at t+2.
  - Ack at t → INT low and InService high at t+1.
- Reset mid-operation: the next cycle returns everything to reset values, with all requests and in-service state dropped.
- isInterrupted with INA not matching an outstanding request is ignored.

Decomposition:
- Shared package (ctrl_pkg) holds:
  - the FSM state encodings IDLE, INT_REQ, SERVICE;
  - constants INA_INT = 1 and INA_NMI = 0;
  - the default NUM_IRQ.
- One sub-module: irq_priority_enc, purely combinational. Inputs are the NUM_IRQ request bits; outputs are the VEC_W index and a valid bit.

Test Plan:
1. Reset, MaskIn = 4'b0000 with MaskWe, Irq[2] rises at cycle 10 → Pending = 4'b0100 at cycle 11, INT = 1 with IrqVec = 2 at cycle 12. Ack with INA = 1 → INT = 0, InService = 1, Pending = 0. Eoi → InService = 0.
2. Irq[3] and Irq[1] rise in the same cycle with mask clear → IrqVec = 1 first. After ack and Eoi, INT reasserts with IrqVec = 3.
3. Mask = 4'b1111, Irq[0] rises → Pending[0] = 1 and INT stays 0. Write MaskIn = 4'b0000 → INT = 1 two cycles later.
4. Eligible Irq[0] with INTD = 1 → INT stays 0. Drop INTD → INT = 1.
5. During SERVICE of vector 2, NmiSrc rises → NMI = 1. Ack with INA = 0 → NMI = 0, NmiActive = 1. Eoi → NmiActive = 0 and InService stays 1. A second Eoi → InService = 0.
6. Irq[1] edge in the same cycle as the ack for vector 1 → Pending[1] stays 1 and is re-presented after Eoi. Assert Reset while in INT_REQ → next cycle INT = 0, Mask = 4'b1111, Pending = 0.
